// File: rtl/fpu_pkg.sv
// fpu_pkg
//   Shared definitions for the FP add/sub pipeline: default field widths,
//   the saturated exponent code, the canonical quiet NaN and the bit
//   positions of the status flags in the 4-bit flag vector.
package fpu_pkg;

    localparam int WIDTH_DEF     = 32;
    localparam int EXP_BITS_DEF  = 8;
    localparam int MANT_BITS_DEF = 23;

    // Biased exponent code reserved for Inf/NaN.
    localparam int EXP_MAX = (1 << EXP_BITS_DEF) - 1;

    localparam logic [31:0] CAN_NAN = 32'h7FC0_0000;

    localparam int FLG_INVALID   = 3;
    localparam int FLG_OVERFLOW  = 2;
    localparam int FLG_UNDERFLOW = 1;
    localparam int FLG_INEXACT   = 0;

endpackage

// File: rtl/fpu_round_rne.sv
// fpu_round_rne
//   Combinational round-to-nearest-even of a normalised mantissa carrying
//   guard/round/sticky bits. A carry out of the hidden bit bumps the exponent;
//   the fraction is then zero because the mantissa was all ones.
// Ports
//   exp_in    in   EXP_BITS+2  signed biased exponent
//   mant_in   in   MANT_BITS+4 {hidden, fraction, G, R, S}
//   exp_out   out  EXP_BITS+2  exponent after rounding carry
//   frac_out  out  MANT_BITS   rounded stored fraction
module fpu_round_rne #(
    parameter int EXP_BITS  = 8,
    parameter int MANT_BITS = 23
) (
    input  logic signed [EXP_BITS+1:0]  exp_in,
    input  logic        [MANT_BITS+3:0] mant_in,
    output logic signed [EXP_BITS+1:0]  exp_out,
    output logic        [MANT_BITS-1:0] frac_out
);

    localparam int EW = EXP_BITS + 2;

    function automatic logic rne_up(input logic lsb, input logic g,
                                    input logic r, input logic s);
        return g & (r | s | lsb);
    endfunction

    logic                 rnd_up;
    logic [MANT_BITS+1:0] sum;
    logic                 carry;
    // The hidden bit is implied by normalisation; only the carry above it matters.
    logic                 hidden_unused;

    assign rnd_up = rne_up(mant_in[3], mant_in[2], mant_in[1], mant_in[0]);
    assign sum    = {1'b0, mant_in[MANT_BITS+3:3]} + {{(MANT_BITS+1){1'b0}}, rnd_up};
    assign {carry, hidden_unused, frac_out} = sum;
    assign exp_out = exp_in + {{(EW-1){1'b0}}, carry};

endmodule

// File: rtl/fpu_result_stage.sv
// fpu_result_stage
//   Output stage of the FP add/sub pipeline. S1 rounds the normalised
//   datapath result (RNE) and registers the exception/zero side-band;
//   S2 packs to IEEE-754 and selects the exception result when flagged.
//   Two-stage valid/ready pipeline with full backpressure, latency 2.
// Ports
//   clk, arst_n            clock, async active-low reset
//   in_valid / in_ready    upstream handshake (in_ready combinational)
//   exc_flag, exc_result   exception block result for this beat
//   nrm_sign/exp/mant/zero normalised datapath result
//   out_valid / out_ready  downstream handshake
//   out_result             final IEEE word
//   out_flags              {invalid, overflow, underflow, inexact}
// Configuration
//   FPU_STATUS_FLAGS_EN defined : status flags computed.
//   FPU_STATUS_FLAGS_EN undefined: out_flags tied to zero.
module fpu_result_stage
    import fpu_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int EXP_BITS  = EXP_BITS_DEF,
    parameter int MANT_BITS = MANT_BITS_DEF
) (
    input  logic                   clk,
    input  logic                   arst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   exc_flag,
    input  logic [WIDTH-1:0]       exc_result,
    input  logic                   nrm_sign,
    input  logic [EXP_BITS+1:0]    nrm_exp,
    input  logic [MANT_BITS+3:0]   nrm_mant,
    input  logic                   nrm_zero,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_result,
    output logic [3:0]             out_flags
);

    localparam int EW = EXP_BITS + 2;
    localparam logic signed [EW-1:0] EXP_SAT = EW'((1 << EXP_BITS) - 1);
    localparam logic signed [EW-1:0] EXP_ONE = EW'(1);

    logic vld_p1, vld_p2;
    logic s1_adv, s2_adv;

    logic signed [EW-1:0]        rnd_exp;
    logic        [MANT_BITS-1:0] rnd_frac;

    logic                        sign_p1;
    logic signed [EW-1:0]        exp_p1;
    logic        [MANT_BITS-1:0] frac_p1;
    logic                        zero_p1;
    logic                        exc_p1;
    logic        [WIDTH-1:0]     exc_res_p1;

    logic        [WIDTH-1:0]     res_nxt;
    logic        [WIDTH-1:0]     res_p2;

    assign s2_adv   = !vld_p2 || out_ready;
    assign s1_adv   = !vld_p1 || s2_adv;
    assign in_ready = s1_adv;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (s1_adv) vld_p1 <= in_valid;
            if (s2_adv) vld_p2 <= vld_p1;
        end
    end

    fpu_round_rne #(
        .EXP_BITS  (EXP_BITS),
        .MANT_BITS (MANT_BITS)
    ) u_round (
        .exp_in   ($signed(nrm_exp)),
        .mant_in  (nrm_mant),
        .exp_out  (rnd_exp),
        .frac_out (rnd_frac)
    );

    // ---- S1: rounded value and side-band ----
    always_ff @(posedge clk) begin
        if (s1_adv && in_valid) begin
            sign_p1    <= nrm_sign;
            exp_p1     <= rnd_exp;
            frac_p1    <= rnd_frac;
            zero_p1    <= nrm_zero;
            exc_p1     <= exc_flag;
            exc_res_p1 <= exc_result;
        end
    end

    // Pack/select, highest priority first.
    always_comb begin
        res_nxt = {sign_p1, exp_p1[EXP_BITS-1:0], frac_p1};
        if (exc_p1)
            res_nxt = exc_res_p1;
        else if (zero_p1)
            res_nxt = '0;
        else if (exp_p1 >= EXP_SAT)
            res_nxt = {sign_p1, {EXP_BITS{1'b1}}, {MANT_BITS{1'b0}}};
        else if (exp_p1 < EXP_ONE)
            res_nxt = {sign_p1, {(WIDTH-1){1'b0}}};
    end

    // ---- S2: packed result ----
    always_ff @(posedge clk) begin
        if (s2_adv && vld_p1) res_p2 <= res_nxt;
    end

    assign out_valid  = vld_p2;
    assign out_result = vld_p2 ? res_p2 : '0;

`ifdef FPU_STATUS_FLAGS_EN
    logic       inexact_p1;
    logic [3:0] flg_nxt;
    logic [3:0] flags_p2;

    always_ff @(posedge clk) begin
        if (s1_adv && in_valid) inexact_p1 <= |nrm_mant[2:0];
    end

    always_comb begin
        flg_nxt = '0;
        if (exc_p1) begin
            flg_nxt[FLG_INVALID] = (&exc_res_p1[WIDTH-2 -: EXP_BITS]) &&
                                   (|exc_res_p1[MANT_BITS-1:0]);
        end else if (zero_p1) begin
            flg_nxt = '0;
        end else if (exp_p1 >= EXP_SAT) begin
            flg_nxt[FLG_OVERFLOW] = 1'b1;
            flg_nxt[FLG_INEXACT]  = 1'b1;
        end else if (exp_p1 < EXP_ONE) begin
            flg_nxt[FLG_UNDERFLOW] = 1'b1;
            flg_nxt[FLG_INEXACT]   = 1'b1;
        end else begin
            flg_nxt[FLG_INEXACT] = inexact_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (s2_adv && vld_p1) flags_p2 <= flg_nxt;
    end

    assign out_flags = vld_p2 ? flags_p2 : 4'b0000;
`else
    assign out_flags = 4'b0000;
`endif

endmodule
